// File: rtl/pkt_tuple_parser_if.sv
// AXI-Stream style bus bundle for the tuple parser packet input and output.
interface pkt_tuple_parser_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/pkt_tuple_parser.sv
// IPv4 TCP/UDP 5-tuple extractor behind a single-register stream pass-through.
// Define PARSER_VLAN_EN to also parse frames carrying one 802.1Q tag.
//   state     | meaning
//   IDLE      | expecting beat 0 of a frame
//   HDR       | capturing header fields
//   WAIT_LAST | tuple emitted or frame rejected; draining to tlast
module pkt_tuple_parser #(
    parameter int IHL_CHECK = 1
) (
    input  logic               clk,
    input  logic               reset,
    pkt_tuple_parser_if.slave  s_axis,
    pkt_tuple_parser_if.master m_axis,
    output logic [127:0]       tuple_data,
    output logic               tuple_valid
);

`ifdef PARSER_VLAN_EN
    localparam bit VLAN_EN = 1'b1;
`else
    localparam bit VLAN_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_HDR       = 2'd1;
    localparam logic [1:0] ST_WAIT_LAST = 2'd2;

    logic [1:0]  state;
    logic [2:0]  beat_idx;
    logic        vlan;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [7:0]  proto;

    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;
    logic        ready;
    logic        hs;
    logic [7:0]  b [8];

    function automatic logic ip_ok(input logic [7:0] ver_ihl);
        return (ver_ihl[7:4] == 4'd4) && ((IHL_CHECK == 0) || (ver_ihl[3:0] == 4'd5));
    endfunction

    function automatic logic proto_ok(input logic [7:0] p);
        return (p == 8'd6) || (p == 8'd17);
    endfunction

    assign ready         = !out_valid || m_axis.tready;
    assign hs            = s_axis.tvalid && ready;
    assign s_axis.tready = ready;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tlast  = out_last;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            b[i] = s_axis.tdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (ready) begin
            out_valid <= s_axis.tvalid;
            if (s_axis.tvalid) begin
                out_data <= s_axis.tdata;
                out_keep <= s_axis.tkeep;
                out_last <= s_axis.tlast;
            end
        end
    end

    // beat_idx always names the beat currently being offered on the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            beat_idx    <= 3'd0;
            vlan        <= 1'b0;
            src_ip      <= '0;
            dst_ip      <= '0;
            src_port    <= '0;
            proto       <= '0;
            tuple_data  <= '0;
            tuple_valid <= 1'b0;
        end else begin
            tuple_valid <= 1'b0;
            if (hs) begin
                if (s_axis.tlast)
                    beat_idx <= 3'd0;
                else if (beat_idx != 3'd7)
                    beat_idx <= beat_idx + 3'd1;

                case (state)
                    ST_IDLE: state <= ST_HDR;
                    ST_HDR: begin
                        case (beat_idx)
                            3'd1: begin
                                vlan <= VLAN_EN && ({b[4], b[5]} == 16'h8100);
                                if (!(VLAN_EN && ({b[4], b[5]} == 16'h8100)) &&
                                    !(({b[4], b[5]} == 16'h0800) && ip_ok(b[6])))
                                    state <= ST_WAIT_LAST;
                            end
                            3'd2: begin
                                if (vlan) begin
                                    if (!(({b[0], b[1]} == 16'h0800) && ip_ok(b[2])))
                                        state <= ST_WAIT_LAST;
                                end else begin
                                    proto <= b[7];
                                    if (!proto_ok(b[7]))
                                        state <= ST_WAIT_LAST;
                                end
                            end
                            3'd3: begin
                                if (vlan) begin
                                    proto          <= b[3];
                                    src_ip[31:16]  <= {b[6], b[7]};
                                    if (!proto_ok(b[3]))
                                        state <= ST_WAIT_LAST;
                                end else begin
                                    src_ip         <= {b[2], b[3], b[4], b[5]};
                                    dst_ip[31:16]  <= {b[6], b[7]};
                                end
                            end
                            3'd4: begin
                                if (vlan) begin
                                    src_ip[15:0] <= {b[0], b[1]};
                                    dst_ip       <= {b[2], b[3], b[4], b[5]};
                                    src_port     <= {b[6], b[7]};
                                end else begin
                                    tuple_data  <= {src_ip, dst_ip[31:16], b[0], b[1],
                                                    b[2], b[3], b[4], b[5], proto, 24'h0};
                                    tuple_valid <= 1'b1;
                                    state       <= ST_WAIT_LAST;
                                end
                            end
                            3'd5: begin
                                tuple_data  <= {src_ip, dst_ip, src_port, b[0], b[1], proto, 24'h0};
                                tuple_valid <= 1'b1;
                                state       <= ST_WAIT_LAST;
                            end
                            default: state <= ST_WAIT_LAST;
                        endcase
                    end
                    default: ;
                endcase

                if (s_axis.tlast)
                    state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pkt_tuple_parser.sv
// Self-checking bench for pkt_tuple_parser: directed vector table, hand sequences, random frames vs. a frame-level model.
module tb_pkt_tuple_parser;

    localparam int IHL_CHK = 1;
`ifdef PARSER_VLAN_EN
    localparam bit VLAN_EN = 1'b1;
`else
    localparam bit VLAN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] tuple_data;
    logic         tuple_valid;

    pkt_tuple_parser_if s_if ();
    pkt_tuple_parser_if m_if ();

    pkt_tuple_parser #(.IHL_CHECK(IHL_CHK)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .tuple_data  (tuple_data),
        .tuple_valid (tuple_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  data;
        logic [7:0]   keep;
        logic         last;
        bit           pulse;
        logic [127:0] tup;
    } beat_t;

    typedef struct {
        logic [15:0]  et;
        logic [7:0]   vi;
        logic [7:0]   pr;
        logic [31:0]  sip;
        logic [31:0]  dip;
        logic [15:0]  sp;
        logic [15:0]  dp;
        bit           tag;
        int           nb;
        bit           exp_p;
        logic [127:0] exp_t;
        int           cb;
    } vec_t;

    localparam int NV = 11;
    vec_t  tbl [NV];
    beat_t q [$];

    int tests = 0;
    int errors = 0;
    int exp_pulses = 0;
    int got_pulses = 0;
    int presented = 0;
    int rdy_mode = 0;
    bit front_pulsed = 0;
    bit sb_en = 0;

    logic [511:0] f;
    logic [127:0] mt;
    bit           mp;
    int           mcb;
    bit           seen;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [511:0] fr, input int i);
        return fr[8*i +: 8];
    endfunction

    function automatic logic [511:0] rand_fill();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] build(input logic [15:0] et, input logic [7:0] vi, input logic [7:0] pr,
                                           input logic [31:0] sip, input logic [31:0] dip,
                                           input logic [15:0] sp, input logic [15:0] dp,
                                           input bit tag, input logic [511:0] fill);
        logic [511:0] fr;
        int o;
        fr = fill;
        o  = tag ? 4 : 0;
        if (tag) begin
            fr[8*12 +: 8] = 8'h81;
            fr[8*13 +: 8] = 8'h00;
        end
        fr[8*(12+o) +: 8] = et[15:8];
        fr[8*(13+o) +: 8] = et[7:0];
        fr[8*(14+o) +: 8] = vi;
        fr[8*(23+o) +: 8] = pr;
        for (int i = 0; i < 4; i++) begin
            fr[8*(26+o+i) +: 8] = sip[31-8*i -: 8];
            fr[8*(30+o+i) +: 8] = dip[31-8*i -: 8];
        end
        for (int i = 0; i < 2; i++) begin
            fr[8*(34+o+i) +: 8] = sp[15-8*i -: 8];
            fr[8*(36+o+i) +: 8] = dp[15-8*i -: 8];
        end
        return fr;
    endfunction

    // Frame-level reference: decide acceptance from the header bytes, then the tuple is bytes 26..37 + proto.
    function automatic void model(input logic [511:0] fr, input int nb,
                                  output bit p, output logic [127:0] t, output int cb);
        int o;
        logic [15:0] et;
        logic [7:0]  vi;
        logic [7:0]  pr;
        o  = 0;
        et = {byte_of(fr, 12), byte_of(fr, 13)};
        if (VLAN_EN && et == 16'h8100) begin
            o  = 4;
            et = {byte_of(fr, 16), byte_of(fr, 17)};
        end
        vi = byte_of(fr, 14 + o);
        pr = byte_of(fr, 23 + o);
        cb = (37 + o) / 8;
        p  = (et == 16'h0800) && (vi[7:4] == 4'd4) && (IHL_CHK == 0 || vi[3:0] == 4'd5) &&
             (pr == 8'd6 || pr == 8'd17) && (nb > cb);
        t  = '0;
        for (int i = 0; i < 12; i++) t[127-8*i -: 8] = byte_of(fr, 26 + o + i);
        t[31:24] = pr;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        while (!done) begin
            @(negedge clk);
            done = s_if.tready;
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                $display("FAIL input_handshake: got no tready in %0d cycles, expected tready", n);
                $fatal(1);
            end
        end
    endtask

    task automatic send_frame(input logic [511:0] fr, input int nb, input logic [7:0] lk, input bit p,
                              input logic [127:0] t, input int cb, input bit gaps, input bit lat);
        beat_t e;
        for (int k = 0; k < nb; k++) begin
            if (gaps && $urandom_range(3) == 0) begin
                s_if.tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            e.data  = fr[64*k +: 64];
            e.keep  = (k == nb - 1) ? lk : 8'hFF;
            e.last  = (k == nb - 1);
            e.pulse = p && (k == cb);
            e.tup   = t;
            if (sb_en) begin
                q.push_back(e);
                if (e.pulse) exp_pulses++;
            end
            send_beat(e.data, e.keep, e.last);
            if (lat) check("latency", {m_if.tvalid, m_if.tdata}, {1'b1, e.data});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        s_if.tvalid = 1'b0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = ($urandom_range(9) < 7);
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Scoreboard: every output beat in order, pulses only on the first cycle the completing beat is shown.
    always @(negedge clk) begin
        if (sb_en && !reset) begin
            if (tuple_valid) begin
                got_pulses++;
                if (q.size() == 0 || !m_if.tvalid) begin
                    check("pulse_stray", tuple_valid, 0);
                end else begin
                    check("pulse_expected", {front_pulsed, q[0].pulse}, 2'b01);
                    check("pulse_timing", presented, 0);
                    check("tuple_data", tuple_data, q[0].tup);
                    front_pulsed = 1'b1;
                end
            end
            if (m_if.tvalid) begin
                if (q.size() == 0) begin
                    check("beat_extra", m_if.tvalid, 0);
                end else if (m_if.tready) begin
                    check("beat", {m_if.tdata, m_if.tkeep, m_if.tlast}, {q[0].data, q[0].keep, q[0].last});
                    if (q[0].pulse) check("pulse_missing", front_pulsed, 1);
                    void'(q.pop_front());
                    front_pulsed = 1'b0;
                    presented    = 0;
                end else begin
                    presented++;
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{16'h0800, 8'h45, 8'h11, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 1'b0, 8,
                    1'b1, 128'h0A000001_0A000002_04D2_0050_11_000000, 4};
        tbl[1]  = '{16'h0806, 8'h45, 8'h11, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 1'b0, 8,
                    1'b0, 128'h0, 4};
        tbl[2]  = '{16'h0800, 8'h45, 8'h06, 32'hC0A80101, 32'hC0A80102, 16'h1F90, 16'h0016, 1'b0, 6,
                    1'b1, 128'hC0A80101_C0A80102_1F90_0016_06_000000, 4};
        tbl[3]  = '{16'h0800, 8'h46, 8'h06, 32'h11111111, 32'h22222222, 16'h0001, 16'h0002, 1'b0, 8,
                    1'b0, 128'h0, 4};
        tbl[4]  = '{16'h0800, 8'h65, 8'h06, 32'h11111111, 32'h22222222, 16'h0001, 16'h0002, 1'b0, 8,
                    1'b0, 128'h0, 4};
        tbl[5]  = '{16'h0800, 8'h45, 8'h01, 32'h11111111, 32'h22222222, 16'h0001, 16'h0002, 1'b0, 8,
                    1'b0, 128'h0, 4};
        tbl[6]  = '{16'h0800, 8'h45, 8'h11, 32'hAC100001, 32'hAC100002, 16'h0035, 16'h0035, 1'b0, 5,
                    1'b1, 128'hAC100001_AC100002_0035_0035_11_000000, 4};
        tbl[7]  = '{16'h0800, 8'h45, 8'h06, 32'h33333333, 32'h44444444, 16'h0101, 16'h0202, 1'b0, 4,
                    1'b0, 128'h0, 4};
        tbl[8]  = '{16'h0800, 8'h45, 8'h06, 32'h01020304, 32'h05060708, 16'h1234, 16'hABCD, 1'b0, 8,
                    1'b1, 128'h01020304_05060708_1234_ABCD_06_000000, 4};
`ifdef PARSER_VLAN_EN
        tbl[9]  = '{16'h0800, 8'h45, 8'h06, 32'hC0A80001, 32'hC0A80002, 16'h01BB, 16'h1388, 1'b1, 8,
                    1'b1, 128'hC0A80001_C0A80002_01BB_1388_06_000000, 5};
`else
        tbl[9]  = '{16'h0800, 8'h45, 8'h06, 32'hC0A80001, 32'hC0A80002, 16'h01BB, 16'h1388, 1'b1, 8,
                    1'b0, 128'h0, 5};
`endif
        tbl[10] = '{16'h0800, 8'h45, 8'h06, 32'h55555555, 32'h66666666, 16'h0303, 16'h0404, 1'b0, 1,
                    1'b0, 128'h0, 4};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_axis", {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata}, 0);
        check("rst_tuple_valid", tuple_valid, 0);
        check("rst_tuple_data", tuple_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", s_if.tready, 1);
        @(posedge clk);
        #1;
        sb_en = 1'b1;

        // Directed table, frames back to back, including truncated-then-valid.
        for (int i = 0; i < NV; i++) begin
            f = build(tbl[i].et, tbl[i].vi, tbl[i].pr, tbl[i].sip, tbl[i].dip, tbl[i].sp, tbl[i].dp,
                      tbl[i].tag, rand_fill());
            send_frame(f, tbl[i].nb, 8'hFF, tbl[i].exp_p, tbl[i].exp_t, tbl[i].cb, 1'b0, 1'b1);
        end
        drain();

        // Output stall for three cycles while beat 2 sits in the output register.
        f = build(16'h0800, 8'h45, 8'h11, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 1'b0, rand_fill());
        seen = 1'b0;
        fork
            send_frame(f, 8, 8'h0F, 1'b1, 128'h0A000001_0A000002_04D2_0050_11_000000, 4, 1'b0, 1'b0);
            begin
                for (int n = 0; n < 50 && !seen; n++) begin
                    @(negedge clk);
                    seen = s_if.tvalid && (s_if.tdata == f[128 +: 64]);
                end
                check("stall_trigger", seen, 1);
                rdy_mode = 2;
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    check("stall_s_ready", s_if.tready, 0);
                    check("stall_hold", {m_if.tvalid, m_if.tdata}, {1'b1, f[128 +: 64]});
                end
                rdy_mode = 0;
            end
        join
        drain();

        // Reset while beat 3 of a TCP frame is offered, then a fresh frame.
        sb_en = 1'b0;
        f = build(16'h0800, 8'h45, 8'h06, 32'h77777777, 32'h88888888, 16'h0050, 16'h0051, 1'b0, rand_fill());
        for (int k = 0; k < 3; k++) send_beat(f[64*k +: 64], 8'hFF, 1'b0);
        s_if.tdata = f[192 +: 64];
        reset      = 1'b1;
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        @(negedge clk);
        check("midrst_m_axis", {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata}, 0);
        check("midrst_tuple_valid", tuple_valid, 0);
        check("midrst_tuple_data", tuple_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", s_if.tready, 1);
        q.delete();
        front_pulsed = 1'b0;
        presented    = 0;
        sb_en        = 1'b1;
        @(posedge clk);
        #1;
        f = build(16'h0800, 8'h45, 8'h06, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'hC000, 16'h0016, 1'b0, rand_fill());
        send_frame(f, 6, 8'h03, 1'b1, 128'h0A0A0A0A_0B0B0B0B_C000_0016_06_000000, 4, 1'b0, 1'b1);
        drain();

        // Random frames with random gaps and output backpressure.
        rdy_mode = 1;
        for (int n = 0; n < 60; n++) begin
            int          r;
            bit          tag;
            logic [15:0] et;
            logic [7:0]  vi;
            logic [7:0]  pr;
            int          nb;
            r   = $urandom_range(9);
            tag = 1'b0;
            et  = 16'h0800;
            if (r == 6) et = 16'h0806;
            else if (r == 7) tag = 1'b1;
            else if (r == 8) et = 16'($urandom);
            vi = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h45;
            case ($urandom_range(3))
                0:       pr = 8'd6;
                1:       pr = 8'd17;
                2:       pr = 8'd6;
                default: pr = 8'($urandom);
            endcase
            nb = $urandom_range(1, 8);
            f  = build(et, vi, pr, $urandom, $urandom, 16'($urandom), 16'($urandom), tag, rand_fill());
            model(f, nb, mp, mt, mcb);
            send_frame(f, nb, 8'($urandom_range(1, 255)), mp, mt, mcb, 1'b1, 1'b0);
        end
        s_if.tvalid = 1'b0;
        rdy_mode    = 0;
        drain();

        check("pulse_count", got_pulses, exp_pulses);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
